sense_change_fifo: RTL and testbench
====================================

# sense_change_fifo

Registered change-capture stage downstream of the combinational sense decoder. Samples the decoder's 2-bit code and 1-bit flag every clock, detects any change, and queues a timestamped change event in a small FIFO. A consumer drains the FIFO through a valid/ready handshake. It is the first sequential stage after the sensitivity-driven decode logic and decouples that logic from a slower reader.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- TS_W, 8: timestamp counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  capture enable; when low, no events are generated and the sample history is invalidated.
- in_code  in  2  decoder code output.
- in_flag  in  1  decoder flag output.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head when evt_valid=1.
- evt_code  out  2  code of the head event.
- evt_flag  out  1  flag of the head event.
- evt_ts  out  TS_W  timestamp of the head event.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky flag; at least one event was dropped.
- clear_ovf  in  1  clears overflow.

## Operation
- Sample register: prev = {in_code,in_flag}, prev_vld. It loads every cycle while enable=1. prev_vld is set after the first enabled cycle. enable=0 clears prev_vld.
- Change detect: push when enable=1, prev_vld=1, and {in_code,in_flag} != prev. The first enabled cycle after reset or after enable drops only primes prev and pushes nothing.
- Timestamp: free-running TS_W counter. Reset value 0. Increments every cycle regardless of enable. Wraps from 2^TS_W-1 to 0 with no flag. A pushed event carries the counter value from the detect cycle, before that edge's increment.
- FIFO: show-ahead. The head is on evt_* whenever evt_valid=1. Pop occurs when evt_valid && evt_ready.
- Push and pop in the same cycle:
  - Not full: both take effect; count is unchanged.
  - Full: pop frees the slot, the push is accepted, and count stays DEPTH.
  - Empty: the push is written, nothing pops (evt_valid was 0), and count becomes 1.
- Full, push, no pop: the event is dropped, FIFO contents are unchanged, and overflow is set.
- overflow: set by a dropped push; cleared by clear_ovf. If a set and clear_ovf occur in the same cycle, set wins.
- evt_* hold a stable value while evt_valid=1 and evt_ready=0. Contents are don't-care when evt_valid=0. The bench must not check them then.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from count.

## Timing
- Reset values: evt_valid=0, count=0, overflow=0, evt_code=0, evt_flag=0, evt_ts=0, timestamp counter 0, prev_vld=0.
- Latency: a change present before edge E is detected at edge E; evt_valid=1 after edge E (1 cycle) if the FIFO was empty.
- Pop at edge E: the next head (or evt_valid=0) is visible after E.
- evt_valid, count, and overflow are driven directly from flops, with no combinational path from evt_ready.
- Reset mid-operation: all queued events are lost immediately, with no handshake completion.

## Structure
- Package sense_pkg holds:
  - the typedef sense_evt_t struct {code[1:0], flag, ts[TS_W-1:0]}, with TS_W as a package localparam default;
  - the constant SENSE_W=3.
- Sub-module sense_fifo: a generic show-ahead synchronous FIFO with parameters WIDTH and DEPTH, and ports push, pop, wdata, rdata, full, empty, count.
- The top level holds the sample register, comparator, timestamp counter, and overflow logic.

## Test plan
- Reset then enable: hold input at 2'b01/0 for 5 cycles. Expected: no event, count=0, evt_valid=0.
- Single change: at ts=10, change to 2'b10/1 with evt_ready=0. Expected: one cycle later evt_valid=1, evt_code=2'b10, evt_flag=1, evt_ts=10, count=1.
- Fill and overflow: DEPTH=4, evt_ready=0, six consecutive changes. Expected: count=4, overflow=1, and the first four events are retained in order. Then clear_ovf leads to overflow=0.
- Full with simultaneous push and pop: evt_ready=1 on a change cycle. Expected: count stays 4, overflow stays 0, the oldest event popped, and the new event at the tail.
- Timestamp wrap: TS_W=4, changes at ts=15 and at the following cycle. Expected: events report evt_ts=15 then 0.
- Asynchronous reset with 3 events queued, asserted mid-cycle. Expected: evt_valid=0, count=0 immediately. After release, the first enabled sample primes only and generates no event.

Source files
------------

// File: rtl/sense_pkg.sv
// rtl/sense_pkg.sv - shared types and constants for the sense change-capture stage
package sense_pkg;

  // Default timestamp width; the top level may override it with its own parameter.
  localparam int TS_W = 8;

  // Width of one decoder sample: 2-bit code plus 1-bit flag.
  localparam int SENSE_W = 3;

  typedef struct packed {
    logic [1:0]      code;
    logic            flag;
    logic [TS_W-1:0] ts;
  } sense_evt_t;

endpackage

// File: rtl/sense_fifo.sv
// rtl/sense_fifo.sv - generic show-ahead synchronous FIFO with occupancy count
module sense_fifo
  import sense_pkg::*;
#(
  parameter int WIDTH = SENSE_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt;
  logic             full_r;
  logic             empty_r;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: a push into a full FIFO only lands when a pop frees a slot.
  always_comb begin
    do_pop    = pop && !empty_r;
    do_push   = push && (!full_r || do_pop);
    count_nxt = count_r;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_r + 1'b1;
      2'b01:   count_nxt = count_r - 1'b1;
      default: count_nxt = count_r;
    endcase
  end

  // Pointers, count and registered full/empty flags derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_r <= count_nxt;
      full_r  <= (count_nxt == FULL_CNT);
      empty_r <= (count_nxt == '0);
    end
  end

  // Storage array; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/sense_change_fifo.sv
// rtl/sense_change_fifo.sv - timestamped change capture of decoder outputs into a FIFO
module sense_change_fifo
  import sense_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 in_code,
  input  logic                       in_flag,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [1:0]                 evt_code,
  output logic                       evt_flag,
  output logic [TS_W-1:0]            evt_ts,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int EW = SENSE_W + TS_W;

  logic [SENSE_W-1:0] cur;
  logic [SENSE_W-1:0] prev;
  logic               prev_vld;
  logic [TS_W-1:0]    ts_cnt;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic [EW-1:0]      wdata;
  logic [EW-1:0]      rdata;

  assign cur = {in_code, in_flag};

  // Sample history: reloads each enabled cycle, invalidated whenever capture is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (enable) begin
      prev     <= cur;
      prev_vld <= 1'b1;
    end else begin
      prev_vld <= 1'b0;
    end
  end

  // Free-running timestamp, independent of enable; wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  // An event is a difference against a valid previous sample; a pop frees room when full.
  always_comb begin
    push = enable && prev_vld && (cur != prev);
    pop  = evt_valid && evt_ready;
    drop = push && full && !pop;
  end

  // Sticky overflow; a drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  assign wdata = {cur, ts_cnt};

  sense_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign evt_valid = !empty;
  assign evt_code  = rdata[EW-1 -: 2];
  assign evt_flag  = rdata[TS_W];
  assign evt_ts    = rdata[TS_W-1:0];

endmodule

// File: tb/tb_sense_change_fifo.sv
// tb/tb_sense_change_fifo.sv - directed vector bench for sense_change_fifo
module tb_sense_change_fifo;

  localparam int DEPTH = 4;
  localparam int TS_W  = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [1:0]       in_code;
  logic             in_flag;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic             evt_flag;
  logic [TS_W-1:0]  evt_ts;
  logic [2:0]       count;
  logic             overflow;
  logic             clear_ovf;

  int tests;
  int fails;

  typedef struct {
    logic            en;
    logic [1:0]      code;
    logic            flag;
    logic            rdy;
    logic            clr;
    logic            ev;
    logic [1:0]      ec;
    logic            ef;
    logic [TS_W-1:0] ets;
    logic [2:0]      cnt;
    logic            ovf;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  sense_change_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_code   (in_code),
    .in_flag   (in_flag),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_flag  (evt_flag),
    .evt_ts    (evt_ts),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic [1:0] code, input logic flag,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [1:0] ec, input logic ef, input logic [TS_W-1:0] ets,
                              input logic [2:0] cnt, input logic ovf);
    vec_t v;
    v.en = en; v.code = code; v.flag = flag; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ec = ec; v.ef = ef; v.ets = ets; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input string tag, input int idx, input vec_t v);
    enable    = v.en;
    in_code   = v.code;
    in_flag   = v.flag;
    evt_ready = v.rdy;
    clear_ovf = v.clr;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, idx, 32'(evt_valid), 32'(v.ev));
    chk({tag, ".count"}, idx, 32'(count), 32'(v.cnt));
    chk({tag, ".overflow"}, idx, 32'(overflow), 32'(v.ovf));
    if (v.ev) begin
      chk({tag, ".code"}, idx, 32'(evt_code), 32'(v.ec));
      chk({tag, ".flag"}, idx, 32'(evt_flag), 32'(v.ef));
      chk({tag, ".ts"}, idx, 32'(evt_ts), 32'(v.ets));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Main table: step k is the k-th rising edge after reset release; event ts = (k-1) mod 16.
    for (int i = 1; i <= 10; i++) tab_a.push_back(mk(1, 2'b01, 0, 0, 0,  0, 2'b00, 0,  0, 0, 0));
    tab_a.push_back(mk(1, 2'b10, 1, 0, 0,  1, 2'b10, 1, 10, 1, 0)); // 11 single change at ts=10
    tab_a.push_back(mk(1, 2'b10, 1, 1, 0,  0, 2'b00, 0,  0, 0, 0)); // 12 drain
    tab_a.push_back(mk(1, 2'b00, 0, 0, 0,  1, 2'b00, 0, 12, 1, 0)); // 13 fill
    tab_a.push_back(mk(1, 2'b01, 1, 0, 0,  1, 2'b00, 0, 12, 2, 0)); // 14
    tab_a.push_back(mk(1, 2'b11, 0, 0, 0,  1, 2'b00, 0, 12, 3, 0)); // 15
    tab_a.push_back(mk(1, 2'b10, 0, 0, 0,  1, 2'b00, 0, 12, 4, 0)); // 16 full
    tab_a.push_back(mk(1, 2'b11, 1, 0, 0,  1, 2'b00, 0, 12, 4, 1)); // 17 dropped
    tab_a.push_back(mk(1, 2'b00, 1, 0, 0,  1, 2'b00, 0, 12, 4, 1)); // 18 dropped
    tab_a.push_back(mk(1, 2'b00, 1, 1, 0,  1, 2'b01, 1, 13, 3, 1)); // 19 order check
    tab_a.push_back(mk(1, 2'b00, 1, 1, 0,  1, 2'b11, 0, 14, 2, 1)); // 20
    tab_a.push_back(mk(1, 2'b00, 1, 1, 0,  1, 2'b10, 0, 15, 1, 1)); // 21
    tab_a.push_back(mk(1, 2'b00, 1, 1, 0,  0, 2'b00, 0,  0, 0, 1)); // 22 empty
    tab_a.push_back(mk(1, 2'b00, 1, 0, 1,  0, 2'b00, 0,  0, 0, 0)); // 23 clear_ovf
    tab_a.push_back(mk(1, 2'b01, 0, 0, 0,  1, 2'b01, 0,  7, 1, 0)); // 24 refill
    tab_a.push_back(mk(1, 2'b10, 0, 0, 0,  1, 2'b01, 0,  7, 2, 0)); // 25
    tab_a.push_back(mk(1, 2'b11, 0, 0, 0,  1, 2'b01, 0,  7, 3, 0)); // 26
    tab_a.push_back(mk(1, 2'b00, 0, 0, 0,  1, 2'b01, 0,  7, 4, 0)); // 27 full
    tab_a.push_back(mk(1, 2'b01, 1, 1, 0,  1, 2'b10, 0,  8, 4, 0)); // 28 full push+pop
    tab_a.push_back(mk(1, 2'b01, 1, 1, 0,  1, 2'b11, 0,  9, 3, 0)); // 29
    tab_a.push_back(mk(1, 2'b01, 1, 1, 0,  1, 2'b00, 0, 10, 2, 0)); // 30
    tab_a.push_back(mk(1, 2'b01, 1, 1, 0,  1, 2'b01, 1, 11, 1, 0)); // 31 new tail
    tab_a.push_back(mk(1, 2'b10, 1, 1, 0,  1, 2'b10, 1, 15, 1, 0)); // 32 push+pop, ts=15
    tab_a.push_back(mk(1, 2'b11, 1, 0, 0,  1, 2'b10, 1, 15, 2, 0)); // 33 ts wrapped to 0
    tab_a.push_back(mk(1, 2'b11, 1, 1, 0,  1, 2'b11, 1,  0, 1, 0)); // 34
    tab_a.push_back(mk(1, 2'b11, 1, 1, 0,  0, 2'b00, 0,  0, 0, 0)); // 35
    tab_a.push_back(mk(1, 2'b00, 0, 1, 0,  1, 2'b00, 0,  3, 1, 0)); // 36 push into empty w/ ready
    tab_a.push_back(mk(1, 2'b00, 0, 1, 0,  0, 2'b00, 0,  0, 0, 0)); // 37
    tab_a.push_back(mk(0, 2'b01, 0, 0, 0,  0, 2'b00, 0,  0, 0, 0)); // 38 disabled
    tab_a.push_back(mk(1, 2'b10, 0, 0, 0,  0, 2'b00, 0,  0, 0, 0)); // 39 re-prime only
    tab_a.push_back(mk(1, 2'b10, 0, 0, 0,  0, 2'b00, 0,  0, 0, 0)); // 40
    tab_a.push_back(mk(1, 2'b11, 0, 0, 0,  1, 2'b11, 0,  8, 1, 0)); // 41
    tab_a.push_back(mk(1, 2'b10, 0, 0, 0,  1, 2'b11, 0,  8, 2, 0)); // 42
    tab_a.push_back(mk(1, 2'b11, 1, 0, 0,  1, 2'b11, 0,  8, 3, 0)); // 43 three queued

    // After the mid-cycle reset: prime, then fill and check set-wins on overflow.
    tab_b.push_back(mk(1, 2'b01, 1, 0, 0,  0, 2'b00, 0,  0, 0, 0)); // 1 primes only
    tab_b.push_back(mk(1, 2'b10, 1, 0, 0,  1, 2'b10, 1,  1, 1, 0)); // 2
    tab_b.push_back(mk(1, 2'b00, 0, 0, 0,  1, 2'b10, 1,  1, 2, 0)); // 3
    tab_b.push_back(mk(1, 2'b01, 0, 0, 0,  1, 2'b10, 1,  1, 3, 0)); // 4
    tab_b.push_back(mk(1, 2'b11, 0, 0, 0,  1, 2'b10, 1,  1, 4, 0)); // 5
    tab_b.push_back(mk(1, 2'b10, 0, 0, 1,  1, 2'b10, 1,  1, 4, 1)); // 6 drop + clear: set wins
    tab_b.push_back(mk(1, 2'b10, 0, 0, 1,  1, 2'b10, 1,  1, 4, 0)); // 7 clear
    tab_b.push_back(mk(1, 2'b10, 0, 1, 0,  1, 2'b00, 0,  2, 3, 0)); // 8 pop

    reset     = 1'b1;
    enable    = 1'b0;
    in_code   = 2'b00;
    in_flag   = 1'b0;
    evt_ready = 1'b0;
    clear_ovf = 1'b0;
    #2;
    chk("rst.valid", 0, 32'(evt_valid), 32'd0);
    chk("rst.count", 0, 32'(count), 32'd0);
    chk("rst.overflow", 0, 32'(overflow), 32'd0);
    chk("rst.code", 0, 32'(evt_code), 32'd0);
    chk("rst.flag", 0, 32'(evt_flag), 32'd0);
    chk("rst.ts", 0, 32'(evt_ts), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tab_a.size(); i++) apply("a", i + 1, tab_a[i]);

    // Asynchronous reset asserted mid-cycle with three events queued.
    #3;
    reset = 1'b1;
    #1;
    chk("arst.valid", 43, 32'(evt_valid), 32'd0);
    chk("arst.count", 43, 32'(count), 32'd0);
    chk("arst.overflow", 43, 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tab_b.size(); i++) apply("b", i + 1, tab_b[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
